// File: rtl/mlp_forward.sv
// rtl/mlp_forward.sv - sequential forward pass of the 16-input, N-hidden, 1-output O/X MLP
// One MAC per cycle: N*16 hidden MACs with ReLU, then N output MACs, then a saturating finish.
module mlp_forward #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int FRAC = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           x,
  input  logic                  label,
  input  logic [N*16*W-1:0]     w_h_bus,
  input  logic [N*W-1:0]        b_h_bus,
  input  logic [N*W-1:0]        w_o_bus,
  input  logic [W-1:0]          b_o_in,
  output logic                  busy,
  output logic                  done,
  output logic [N*(W+5)-1:0]    h_act_bus,
  output logic [W-1:0]          y_out,
  output logic [W-1:0]          err,
  output logic                  pred
);

  localparam int HRAW_W = W + 5;
  localparam int PROD_W = HRAW_W + W;
  localparam int OACC_W = HRAW_W + W + 4;
  localparam int IW     = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [OACC_W:0] Y_MAX = (OACC_W+1)'(2**(W-1) - 1);
  localparam logic signed [OACC_W:0] Y_MIN = (OACC_W+1)'(-(2**(W-1)));
  localparam logic signed [W+1:0]    E_MAX = (W+2)'(2**(W-1) - 1);
  localparam logic signed [W+1:0]    E_MIN = (W+2)'(-(2**(W-1)));
  localparam logic signed [W+1:0]    T_POS = (W+2)'(2**FRAC);
  localparam logic signed [W+1:0]    T_NEG = (W+2)'(-(2**FRAC));

  typedef enum logic [2:0] {S_IDLE, S_HID, S_OUT, S_FIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]             i_idx, k_idx;
  logic [3:0]                j_idx;
  logic [15:0]               x_q;
  logic                      label_q;
  logic signed [HRAW_W-1:0]  hacc;
  logic signed [HRAW_W-1:0]  h_rf [N];
  logic signed [OACC_W-1:0]  oacc;

  logic                      last_neuron;
  logic signed [W-1:0]       w_cur, b_next, w_o_cur;
  logic signed [HRAW_W-1:0]  h_term, hacc_sum, h_relu, b0_ext, b_next_ext;
  logic signed [PROD_W-1:0]  h_mul, w_mul, o_prod;
  logic signed [OACC_W-1:0]  o_prod_ext, oacc_sh;
  logic signed [OACC_W:0]    ysum;
  logic signed [W-1:0]       y_sat, err_sat;
  logic signed [W+1:0]       tgt, ediff;

  always_comb begin
    last_neuron = (int'(i_idx) == N - 1);
    w_cur       = w_h_bus[(int'(i_idx) * 16 + int'(j_idx)) * W +: W];
    b_next      = b_h_bus[(last_neuron ? 0 : int'(i_idx) + 1) * W +: W];
    w_o_cur     = w_o_bus[int'(k_idx) * W +: W];
    b0_ext      = {{(HRAW_W-W){b_h_bus[W-1]}}, b_h_bus[W-1:0]};
    b_next_ext  = {{(HRAW_W-W){b_next[W-1]}}, b_next};
    h_term      = {{(HRAW_W-W){w_cur[W-1]}}, w_cur};
    if (!x_q[j_idx]) h_term = -h_term;
    hacc_sum    = hacc + h_term;
    h_relu      = hacc_sum[HRAW_W-1] ? '0 : hacc_sum;
    h_mul       = {{W{h_rf[k_idx][HRAW_W-1]}}, h_rf[k_idx]};
    w_mul       = {{HRAW_W{w_o_cur[W-1]}}, w_o_cur};
    o_prod      = h_mul * w_mul;
    o_prod_ext  = {{(OACC_W-PROD_W){o_prod[PROD_W-1]}}, o_prod};
  end

  // Finish stage: err is formed against the already-saturated score.
  always_comb begin
    oacc_sh = oacc >>> FRAC;
    ysum    = {oacc_sh[OACC_W-1], oacc_sh} + {{(OACC_W+1-W){b_o_in[W-1]}}, b_o_in};
    if (ysum > Y_MAX)      y_sat = Y_MAX[W-1:0];
    else if (ysum < Y_MIN) y_sat = Y_MIN[W-1:0];
    else                   y_sat = ysum[W-1:0];
    tgt   = label_q ? T_POS : T_NEG;
    ediff = tgt - {{2{y_sat[W-1]}}, y_sat};
    if (ediff > E_MAX)      err_sat = E_MAX[W-1:0];
    else if (ediff < E_MIN) err_sat = E_MIN[W-1:0];
    else                    err_sat = ediff[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE: if (start) state_nxt = S_HID;
      S_HID:  if (last_neuron && j_idx == 4'd15) state_nxt = S_OUT;
      S_OUT:  if (int'(k_idx) == N - 1) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      x_q       <= '0;
      label_q   <= 1'b0;
      hacc      <= '0;
      oacc      <= '0;
      h_act_bus <= '0;
      y_out     <= '0;
      err       <= '0;
      pred      <= 1'b0;
      for (int n = 0; n < N; n++) h_rf[n] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_q     <= x;
          label_q <= label;
          i_idx   <= '0;
          j_idx   <= '0;
          hacc    <= b0_ext;
        end
        S_HID: begin
          hacc  <= hacc_sum;
          j_idx <= j_idx + 4'd1;
          if (j_idx == 4'd15) begin
            h_rf[i_idx] <= h_relu;
            hacc        <= b_next_ext;
            if (last_neuron) begin
              i_idx <= '0;
              k_idx <= '0;
              oacc  <= '0;
            end else begin
              i_idx <= i_idx + 1'b1;
            end
          end
        end
        S_OUT: begin
          oacc  <= oacc + o_prod_ext;
          k_idx <= (int'(k_idx) == N - 1) ? '0 : k_idx + 1'b1;
        end
        S_FIN: begin
          y_out <= y_sat;
          err   <= err_sat;
          pred  <= ~y_sat[W-1];
          for (int n = 0; n < N; n++) h_act_bus[n*HRAW_W +: HRAW_W] <= h_rf[n];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_forward.sv
// tb/tb_mlp_forward.sv - scoreboard bench for mlp_forward
// Directed vectors push expected results; a done-triggered monitor pops and compares.
module tb_mlp_forward;
  localparam int W = 8, N = 8, FRAC = 6, HW = W + 5, LAT = 17 * N + 1;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, label = 1'b0;
  logic [15:0]       x = '0;
  logic [N*16*W-1:0] w_h_bus = '0;
  logic [N*W-1:0]    b_h_bus = '0, w_o_bus = '0;
  logic [W-1:0]      b_o_in = '0;
  logic              busy, done, pred;
  logic [N*HW-1:0]   h_act_bus;
  logic [W-1:0]      y_out, err;

  mlp_forward #(.W(W), .N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .label(label),
    .w_h_bus(w_h_bus), .b_h_bus(b_h_bus), .w_o_bus(w_o_bus), .b_o_in(b_o_in),
    .busy(busy), .done(done), .h_act_bus(h_act_bus), .y_out(y_out), .err(err), .pred(pred)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]    y;
    logic [W-1:0]    e;
    logic            p;
    logic [N*HW-1:0] h;
    int              cyc;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*HW-1:0] hbus(input int h0, input int hr);
    logic [N*HW-1:0] r;
    for (int i = 0; i < N; i++) r[i*HW +: HW] = HW'((i == 0) ? h0 : hr);
    return r;
  endfunction

  task automatic set_params(input int wh_rest, input int wh0, input int bh0,
                            input int wo0, input int wo_rest, input int bo);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 16; j++) w_h_bus[(i*16+j)*W +: W] = W'((i == 0) ? wh0 : wh_rest);
      b_h_bus[i*W +: W] = W'((i == 0) ? bh0 : 0);
      w_o_bus[i*W +: W] = W'((i == 0) ? wo0 : wo_rest);
    end
    b_o_in = W'(bo);
  endtask

  // Drives start for one cycle; returns the edge at which it is sampled.
  task automatic issue(input bit push, input int y, input int e, input bit p,
                       input logic [N*HW-1:0] h, output int t_edge);
    exp_t ex;
    @(negedge clk);
    start  = 1'b1;
    t_edge = cyc + 1;
    if (push) begin
      ex.y = W'(y); ex.e = W'(e); ex.p = p; ex.h = h; ex.cyc = t_edge + LAT;
      sbq.push_back(ex);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400 && sbq.size() != 0; t++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got pending=%0d expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        exp_t ex;
        ex = sbq.pop_front();
        check("done_cycle", cyc, ex.cyc);
        check("y_out", y_out, ex.y);
        check("err", err, ex.e);
        check("pred", pred, ex.p);
        check("h_act_bus", h_act_bus, ex.h);
        check("busy_at_done", busy, 1'b1);
      end
    end
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_y", y_out, '0);
    check("rst_err", err, '0);
    check("rst_pred", pred, 1'b0);
    check("rst_h", h_act_bus, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // All zero parameters, label=1
    set_params(0, 0, 0, 0, 0, 0); x = 16'h0000; label = 1'b1;
    issue(1, 0, 64, 1'b1, hbus(0, 0), t0);
    repeat (5) @(negedge clk);
    check("busy_mid", busy, 1'b1);
    wait_done();
    check("busy_after", busy, 1'b0);

    // Saturation on both y_out and err
    set_params(1, 1, 0, 64, 64, 0); x = 16'hFFFF; label = 1'b0;
    issue(1, 127, -128, 1'b1, hbus(16, 16), t0);
    wait_done();

    // ReLU clamps everything, bias alone drives the score
    set_params(1, 1, 0, 64, 64, 10); x = 16'h0000; label = 1'b1;
    issue(1, 10, 54, 1'b1, hbus(0, 0), t0);
    wait_done();

    // Single active neuron, negative score; start pulses while busy must be ignored
    set_params(0, 2, -5, -64, 0, 0); x = 16'h0FFF; label = 1'b0;
    issue(1, -11, -53, 1'b0, hbus(11, 0), t0);
    while (cyc < t0 + LAT + 2) begin
      @(negedge clk);
      start = ((cyc + 1 - t0) inside {5, LAT - 1, LAT, LAT + 1});
    end
    start = 1'b0;
    wait_done();
    repeat (160) @(negedge clk);

    // Reset mid-run abandons the inference
    issue(0, 0, 0, 1'b0, '0, t0);
    while (cyc + 1 < t0 + 50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_y", y_out, '0);
    check("abort_err", err, '0);
    check("abort_pred", pred, 1'b0);
    check("abort_h", h_act_bus, '0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    // Fresh run after reset
    set_params(1, 1, 0, 64, 64, 0); x = 16'hFFFF; label = 1'b1;
    issue(1, 127, -63, 1'b1, hbus(16, 16), t0);
    wait_done();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
